// File: rtl/beta_dmem.sv
`default_nettype none
// ============================================================================
// Module   : beta_dmem
// Brief    : Single-port synchronous data memory behind the LSU. Separate
//            read and write request ports (req/ready/valid) are round-robin
//            arbitrated onto one SRAM array, one access in flight at a time.
//            Optional feature macro: BETA_DMEM_ERR_EN (address/strobe error
//            detection reported on dmem_err_o).
// Revision : 1.0 - initial release
// ============================================================================
module beta_dmem #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int Depth        = 1024,
  parameter int Latency      = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    rdata_req_i,
  input  logic [AddressWidth-1:0] rdata_addr_i,
  input  logic [DataWidth/8-1:0]  rdata_strb_i,
  output logic                    rdata_ready_o,
  output logic                    rdata_valid_o,
  output logic [DataWidth-1:0]    rdata_data_o,
  input  logic                    wdata_req_i,
  input  logic [AddressWidth-1:0] wdata_addr_i,
  input  logic [DataWidth/8-1:0]  wdata_strb_i,
  input  logic [DataWidth-1:0]    wdata_data_i,
  output logic                    wdata_ready_o,
  output logic                    wdata_valid_o,
  output logic                    dmem_err_o
);

  localparam int STRB_W = DataWidth / 8;
  localparam int IDX_W  = $clog2(Depth);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  // ACCEPT counts as the first latency cycle, so valid lands Latency cycles
  // after the ready pulse.
  localparam logic [1:0] CNT_INIT = 2'(Latency - 1);

  logic [1:0]              state;
  logic [1:0]              next_state;
  logic [1:0]              cnt;
  logic [1:0]              cnt_next;
  logic                    last_grant;
  logic                    last_grant_next;

  logic                    grant_any;
  logic                    grant_dir;
  logic                    conflict;
  logic                    access;

  logic [AddressWidth-1:0] addr_q;
  logic [STRB_W-1:0]       strb_q;
  logic [DataWidth-1:0]    data_q;
  logic                    dir_q;

  logic [IDX_W-1:0]        idx;
  logic [DataWidth-1:0]    word;
  logic [DataWidth-1:0]    lane_mask;
  logic                    access_err;
  logic                    mem_we;

  logic                    rready_nxt;
  logic                    wready_nxt;
  logic                    rvalid_nxt;
  logic                    wvalid_nxt;
  logic                    err_nxt;
  logic [DataWidth-1:0]    rdata_nxt;

  logic [DataWidth-1:0]    mem [Depth];

  // Word index; high address bits and the byte offset are ignored here.
  assign idx  = addr_q[IDX_W+1:2];
  assign word = mem[idx];

  // Expand the latched strobe into a bit mask, one byte per lane.
  for (genvar i = 0; i < STRB_W; i++) begin : g_lane
    assign lane_mask[8*i +: 8] = {8{strb_q[i]}};
  end

`ifdef BETA_DMEM_ERR_EN
  // Error: word index would wrap, or a misaligned address with a multi-byte strobe.
  assign access_err = (|addr_q[AddressWidth-1:IDX_W+2]) ||
                      ((addr_q[1:0] != 2'b00) &&
                       ((strb_q & (strb_q - STRB_W'(1))) != '0));
`else
  logic unused_addr;
  assign access_err  = 1'b0;
  assign unused_addr = ^{addr_q[AddressWidth-1:IDX_W+2], addr_q[1:0]};
`endif

  // State register, latency counter and round-robin history.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      last_grant <= DIR_WRITE;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      last_grant <= last_grant_next;
    end
  end

  // Next-state logic: arbitration in IDLE, latency countdown afterwards.
  always_comb begin
    next_state      = state;
    cnt_next        = cnt;
    last_grant_next = last_grant;
    grant_any       = 1'b0;
    grant_dir       = DIR_READ;
    conflict        = 1'b0;
    access          = 1'b0;
    case (state)
      ST_IDLE: begin
        conflict = rdata_req_i && wdata_req_i;
        if (conflict) begin
          grant_any       = 1'b1;
          grant_dir       = (last_grant == DIR_WRITE) ? DIR_READ : DIR_WRITE;
          last_grant_next = grant_dir;
        end else if (rdata_req_i) begin
          grant_any = 1'b1;
          grant_dir = DIR_READ;
        end else if (wdata_req_i) begin
          grant_any = 1'b1;
          grant_dir = DIR_WRITE;
        end
        if (grant_any) begin
          next_state = ST_ACCEPT;
          cnt_next   = CNT_INIT;
        end
      end
      ST_ACCEPT, ST_BUSY: begin
        if (cnt == 2'd0) begin
          access     = 1'b1;
          next_state = ST_IDLE;
        end else begin
          cnt_next   = cnt - 2'd1;
          next_state = ST_BUSY;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered handshake and data outputs.
  always_comb begin
    rready_nxt = grant_any && (grant_dir == DIR_READ);
    wready_nxt = grant_any && (grant_dir == DIR_WRITE);
    rvalid_nxt = access && (dir_q == DIR_READ);
    wvalid_nxt = access && (dir_q == DIR_WRITE);
    err_nxt    = access && access_err;
    mem_we     = wvalid_nxt && !access_err;
    rdata_nxt  = rdata_data_o;
    if (rvalid_nxt) begin
      rdata_nxt = access_err ? '0 : (word & lane_mask);
    end
  end

  // Registered outputs; all return to idle values immediately on reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_ready_o <= 1'b0;
      wdata_ready_o <= 1'b0;
      rdata_valid_o <= 1'b0;
      wdata_valid_o <= 1'b0;
      dmem_err_o    <= 1'b0;
      rdata_data_o  <= '0;
    end else begin
      rdata_ready_o <= rready_nxt;
      wdata_ready_o <= wready_nxt;
      rdata_valid_o <= rvalid_nxt;
      wdata_valid_o <= wvalid_nxt;
      dmem_err_o    <= err_nxt;
      rdata_data_o  <= rdata_nxt;
    end
  end

  // Latch the winning request; the ports are not looked at again until IDLE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q <= '0;
      strb_q <= '0;
      data_q <= '0;
      dir_q  <= DIR_READ;
    end else if (grant_any) begin
      dir_q <= grant_dir;
      if (grant_dir == DIR_WRITE) begin
        addr_q <= wdata_addr_i;
        strb_q <= wdata_strb_i;
        data_q <= wdata_data_i;
      end else begin
        addr_q <= rdata_addr_i;
        strb_q <= rdata_strb_i;
      end
    end
  end

  // Array write, byte-lane enabled; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_q[i]) begin
          mem[idx][8*i +: 8] <= data_q[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beta_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_dmem
// Brief    : Self-checking bench for beta_dmem with Latency 1 and Latency 4
//            instances; read data is checked against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beta_dmem;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic        clk = 1'b0;
  logic        rstn_a = 1'b0;
  logic        rstn_b = 1'b0;

  logic        a_rreq = 1'b0, a_wreq = 1'b0;
  logic [31:0] a_raddr = '0, a_waddr = '0, a_wdata = '0;
  logic [3:0]  a_rstrb = '0, a_wstrb = '0;
  logic        a_rready, a_rvalid, a_wready, a_wvalid, a_err;
  logic [31:0] a_rdata;

  logic        b_rreq = 1'b0, b_wreq = 1'b0;
  logic [31:0] b_raddr = '0, b_waddr = '0, b_wdata = '0;
  logic [3:0]  b_rstrb = '0, b_wstrb = '0;
  logic        b_rready, b_rvalid, b_wready, b_wvalid, b_err;
  logic [31:0] b_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  beta_dmem #(.Latency(LAT_A)) u_dut_a (
    .clk_i(clk), .rstn_i(rstn_a),
    .rdata_req_i(a_rreq), .rdata_addr_i(a_raddr), .rdata_strb_i(a_rstrb),
    .rdata_ready_o(a_rready), .rdata_valid_o(a_rvalid), .rdata_data_o(a_rdata),
    .wdata_req_i(a_wreq), .wdata_addr_i(a_waddr), .wdata_strb_i(a_wstrb),
    .wdata_data_i(a_wdata), .wdata_ready_o(a_wready), .wdata_valid_o(a_wvalid),
    .dmem_err_o(a_err)
  );

  beta_dmem #(.Latency(LAT_B)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn_b),
    .rdata_req_i(b_rreq), .rdata_addr_i(b_raddr), .rdata_strb_i(b_rstrb),
    .rdata_ready_o(b_rready), .rdata_valid_o(b_rvalid), .rdata_data_o(b_rdata),
    .wdata_req_i(b_wreq), .wdata_addr_i(b_waddr), .wdata_strb_i(b_wstrb),
    .wdata_data_i(b_wdata), .wdata_ready_o(b_wready), .wdata_valid_o(b_wvalid),
    .dmem_err_o(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_of(input bit b, input bit wr);
    if (b) return wr ? b_wready : b_rready;
    return wr ? a_wready : a_rready;
  endfunction

  function automatic logic valid_of(input bit b, input bit wr);
    if (b) return wr ? b_wvalid : b_rvalid;
    return wr ? a_wvalid : a_rvalid;
  endfunction

  function automatic logic other_busy(input bit b, input bit wr);
    if (b) return wr ? (b_rready | b_rvalid) : (b_wready | b_wvalid);
    return wr ? (a_rready | a_rvalid) : (a_wready | a_wvalid);
  endfunction

  task automatic drive(input bit b, input bit wr, input logic req,
                       input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data);
    if (b) begin
      if (wr) begin b_wreq = req; b_waddr = addr; b_wstrb = strb; b_wdata = data; end
      else    begin b_rreq = req; b_raddr = addr; b_rstrb = strb; end
    end else begin
      if (wr) begin a_wreq = req; a_waddr = addr; a_wstrb = strb; a_wdata = data; end
      else    begin a_rreq = req; a_raddr = addr; a_rstrb = strb; end
    end
  endtask

  // One complete access with handshake timing checks; entered and left #1 after a rising edge.
  task automatic xfer(input bit b, input bit wr, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] data,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    lat = b ? LAT_B : LAT_A;
    drive(b, wr, 1'b1, addr, strb, data);
    if (!wr) begin
      if (b) qb.push_back(exp_rd); else qa.push_back(exp_rd);
    end
    @(negedge clk);
    chk({tag, "_ready_T"}, 32'(ready_of(b, wr)), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_ready_T1"}, 32'(ready_of(b, wr)), 32'd1);
    chk({tag, "_valid_T1"}, 32'(valid_of(b, wr)), 32'd0);
    @(posedge clk); #1;
    drive(b, wr, 1'b0, addr, strb, data);
    for (int k = 2; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("%s_wait_T%0d", tag, k), 32'({ready_of(b, wr), valid_of(b, wr)}), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_valid"}, 32'(valid_of(b, wr)), 32'd1);
    chk({tag, "_ready_at_valid"}, 32'(ready_of(b, wr)), 32'd0);
    chk({tag, "_other_port"}, 32'(other_busy(b, wr)), 32'd0);
    chk({tag, "_err"}, 32'(b ? b_err : a_err), 32'(exp_err));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_valid_pulse"}, 32'(valid_of(b, wr)), 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every read valid pops the oldest expected word.
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $error("FAIL a_rdata_unexpected: observed %h expected no read", a_rdata);
      end else begin
        chk("a_rdata", a_rdata, qa.pop_front());
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $error("FAIL b_rdata_unexpected: observed %h expected no read", b_rdata);
      end else begin
        chk("b_rdata", b_rdata, qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_outs", {a_rready, a_rvalid, a_wready, a_wvalid, a_err}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_outs", {b_rready, b_rvalid, b_wready, b_wvalid, b_err}, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    @(posedge clk); #1;

    // Latency 1: basic write then read.
    xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "a_wr10");
    xfer(0, 0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, "a_rd10");

    // Partial strobes and an empty strobe.
    xfer(0, 1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, "a_wr20_full");
    xfer(0, 1, 32'h20, 4'h1, 32'h000000AA, 32'h0, 1'b0, "a_wr20_lane0");
    xfer(0, 0, 32'h20, 4'hF, 32'h0, 32'h112233AA, 1'b0, "a_rd20_full");
    xfer(0, 0, 32'h20, 4'h3, 32'h0, 32'h000033AA, 1'b0, "a_rd20_low");
    xfer(0, 1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, "a_wr20_none");
    xfer(0, 0, 32'h22, 4'hC, 32'h0, 32'h11220000, 1'b0, "a_rd20_high");
    chk("a_rdata_hold", a_rdata, 32'h11220000);

    // Out-of-range address: wraps, or flags an error with the feature enabled.
    xfer(0, 1, 32'h0, 4'hF, 32'h01020304, 32'h0, 1'b0, "a_wr0");
`ifdef BETA_DMEM_ERR_EN
    xfer(0, 1, 32'h1000, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b1, "a_wr_wrap");
    xfer(0, 0, 32'h0, 4'hF, 32'h0, 32'h01020304, 1'b0, "a_rd0");
`else
    xfer(0, 1, 32'h1000, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0, "a_wr_wrap");
    xfer(0, 0, 32'h0, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0, "a_rd0");
`endif

    // Arbitration: fresh reset, then two back-to-back conflicts.
    rstn_a = 1'b0;
    @(posedge clk); #1;
    rstn_a = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 32'h10, 4'hF, 32'h0);
    qa.push_back(32'hDEADBEEF);
    drive(0, 1, 1'b1, 32'h40, 4'hF, 32'h0BADCAFE);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cf1_rready", 32'(a_rready), 32'd1);
    chk("cf1_wready_lose", 32'(a_wready), 32'd0);
    @(posedge clk); #1;
    a_rreq = 1'b0;
    @(negedge clk);
    chk("cf1_rvalid", 32'(a_rvalid), 32'd1);
    chk("cf1_wready_wait", 32'(a_wready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cf1_wready", 32'(a_wready), 32'd1);
    chk("cf1_r_idle", 32'({a_rready, a_rvalid}), 32'd0);
    @(posedge clk); #1;
    a_wdata = 32'h600DF00D;
    drive(0, 0, 1'b1, 32'h40, 4'hF, 32'h0);
    qa.push_back(32'h600DF00D);
    @(negedge clk);
    chk("cf1_wvalid", 32'(a_wvalid), 32'd1);
    chk("cf1_rdata_hold", a_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cf2_wready", 32'(a_wready), 32'd1);
    chk("cf2_rready_lose", 32'(a_rready), 32'd0);
    @(posedge clk); #1;
    a_wreq = 1'b0;
    @(negedge clk);
    chk("cf2_wvalid", 32'(a_wvalid), 32'd1);
    chk("cf2_rready_wait", 32'(a_rready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cf2_rready", 32'(a_rready), 32'd1);
    @(posedge clk); #1;
    a_rreq = 1'b0;
    @(negedge clk);
    chk("cf2_rvalid", 32'(a_rvalid), 32'd1);
    @(posedge clk); #1;

    // Latency 4 instance.
    xfer(1, 1, 32'h30, 4'hF, 32'h00000000, 32'h0, 1'b0, "b_wr30");
    xfer(1, 1, 32'h40, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, "b_wr40");
    xfer(1, 0, 32'h40, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, "b_rd40");

    // Reset during BUSY of a write: outputs clear at once, array untouched.
    drive(1, 1, 1'b1, 32'h30, 4'hF, 32'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_rst_wready", 32'(b_wready), 32'd1);
    @(posedge clk); #1;
    drive(1, 1, 1'b0, 32'h30, 4'hF, 32'h12345678);
    @(negedge clk);
    rstn_b = 1'b0;
    #1;
    chk("b_rst_outs", {b_rready, b_rvalid, b_wready, b_wvalid, b_err}, 32'd0);
    chk("b_rst_rdata", b_rdata, 32'd0);
    @(posedge clk); #1;
    rstn_b = 1'b1;
    @(posedge clk); #1;
    xfer(1, 0, 32'h30, 4'hF, 32'h0, 32'h00000000, 1'b0, "b_rd30_after_rst");

    repeat (3) @(posedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
